// File: rtl/interrupt_sequencer_if.sv
// Bus and handshake bundle between the interrupt sequencer and the CPU core / interrupt controller.
interface interrupt_sequencer_if;
  logic        int_req;
  logic        nmi_pend;
  logic        brk_go;
  logic        op_fetch;
  logic [15:0] pc_in;
  logic [7:0]  p_in;
  logic [7:0]  sp_in;
  logic [7:0]  din;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        rw;
  logic        busy;
  logic        sp_dec;
  logic        pc_load;
  logic [15:0] pc_vec;
  logic        set_i;
  logic        int_clr;
  logic        nmi_clr;

  modport slave (
    input  int_req, nmi_pend, brk_go, op_fetch, pc_in, p_in, sp_in, din,
    output addr, dout, rw, busy, sp_dec, pc_load, pc_vec, set_i, int_clr, nmi_clr
  );

  modport master (
    output int_req, nmi_pend, brk_go, op_fetch, pc_in, p_in, sp_in, din,
    input  addr, dout, rw, busy, sp_dec, pc_load, pc_vec, set_i, int_clr, nmi_clr
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// 6502 seven-cycle interrupt entry (RESET/NMI/IRQ/BRK): dummy read, push PCH/PCL/P, vector fetch.
// Optional macro NMI_HIJACK_EN: a pending NMI at T4 redirects an IRQ/BRK entry to the NMI vector.
module interrupt_sequencer #(
  parameter logic [15:0] VEC_NMI    = 16'hFFFA,
  parameter logic [15:0] VEC_RST    = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ    = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE = 8'h01
) (
  input  logic sys_clock,
  input  logic rst,
  input  logic clk_ph1,
  interrupt_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6} state_t;
  typedef enum logic [1:0] {K_RST, K_IRQ, K_BRK} kind_t;

  state_t      state;
  kind_t       kind;
  logic [15:0] vec;
  logic [7:0]  vec_lo;
  logic [7:0]  vec_hi;
  logic        busy_q;
  logic        rw_q;
  logic        sp_dec_q;
  logic        set_i_q;
  logic        pc_load_q;
  logic        int_clr_q;
  logic        nmi_clr_q;

  // Strobes are computed for the state being entered so they are registered and last exactly one step.
  always_ff @(posedge sys_clock or negedge rst) begin
    if (!rst) begin
      state     <= S_T1;
      kind      <= K_RST;
      vec       <= VEC_RST;
      vec_lo    <= 8'h00;
      vec_hi    <= 8'h00;
      busy_q    <= 1'b1;
      rw_q      <= 1'b1;
      sp_dec_q  <= 1'b0;
      set_i_q   <= 1'b0;
      pc_load_q <= 1'b0;
      int_clr_q <= 1'b0;
      nmi_clr_q <= 1'b0;
    end else if (clk_ph1) begin
      rw_q      <= 1'b1;
      sp_dec_q  <= 1'b0;
      set_i_q   <= 1'b0;
      pc_load_q <= 1'b0;
      int_clr_q <= 1'b0;
      nmi_clr_q <= 1'b0;
      case (state)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (bus.op_fetch && (bus.int_req || bus.brk_go)) begin
            state  <= S_T1;
            kind   <= bus.brk_go ? K_BRK : K_IRQ;
            vec    <= bus.nmi_pend ? VEC_NMI : VEC_IRQ;
            busy_q <= 1'b1;
          end
        end
        S_T1: begin
          state    <= S_T2;
          rw_q     <= (kind == K_RST);
          sp_dec_q <= 1'b1;
        end
        S_T2: begin
          state    <= S_T3;
          rw_q     <= (kind == K_RST);
          sp_dec_q <= 1'b1;
        end
        S_T3: begin
          state    <= S_T4;
          rw_q     <= (kind == K_RST);
          sp_dec_q <= 1'b1;
        end
        S_T4: begin
          state   <= S_T5;
          set_i_q <= 1'b1;
`ifdef NMI_HIJACK_EN
          if (kind != K_RST && bus.nmi_pend) vec <= VEC_NMI;
`endif
        end
        S_T5: begin
          state     <= S_T6;
          vec_lo    <= bus.din;
          pc_load_q <= 1'b1;
          int_clr_q <= 1'b1;
          nmi_clr_q <= (vec == VEC_NMI);
        end
        S_T6: begin
          state  <= S_IDLE;
          vec_hi <= bus.din;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Push addresses follow the live SP, which the core decrements on each sp_dec step.
  always_comb begin
    bus.addr = bus.pc_in;
    bus.dout = 8'h00;
    case (state)
      S_T2: begin
        bus.addr = {STACK_PAGE, bus.sp_in};
        bus.dout = bus.pc_in[15:8];
      end
      S_T3: begin
        bus.addr = {STACK_PAGE, bus.sp_in};
        bus.dout = bus.pc_in[7:0];
      end
      S_T4: begin
        bus.addr = {STACK_PAGE, bus.sp_in};
        bus.dout = ((bus.p_in | 8'h20) & 8'hEF) | ((kind == K_BRK) ? 8'h10 : 8'h00);
      end
      S_T5:    bus.addr = vec;
      S_T6:    bus.addr = vec + 16'd1;
      default: bus.addr = bus.pc_in;
    endcase
  end

  // During T6 the high byte comes straight off the bus so pc_load sees the full vector.
  assign bus.pc_vec  = {(state == S_T6) ? bus.din : vec_hi, vec_lo};
  assign bus.busy    = busy_q;
  assign bus.rw      = rw_q;
  assign bus.sp_dec  = sp_dec_q;
  assign bus.set_i   = set_i_q;
  assign bus.pc_load = pc_load_q;
  assign bus.int_clr = int_clr_q;
  assign bus.nmi_clr = nmi_clr_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer; acts as core (SP decrement) and vector ROM.
module tb_interrupt_sequencer;

  logic sys_clock = 1'b0;
  logic rst;
  logic clk_ph1;
  int   tests  = 0;
  int   failed = 0;

  interrupt_sequencer_if ifc ();

  interrupt_sequencer dut (
    .sys_clock (sys_clock),
    .rst       (rst),
    .clk_ph1   (clk_ph1),
    .bus       (ifc.slave)
  );

  always #5 sys_clock = ~sys_clock;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'h00;
      16'hFFFB: return 8'h90;
      16'hFFFC: return 8'h00;
      16'hFFFD: return 8'h80;
      16'hFFFE: return 8'h00;
      16'hFFFF: return 8'hA0;
      default:  return 8'hEA;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: the core model decrements SP on a strobed Phi1 step, and the ROM answers the new address.
  task automatic step();
    logic dec;
    dec = ifc.sp_dec && clk_ph1;
    @(posedge sys_clock);
    #1;
    if (dec) ifc.sp_in = ifc.sp_in - 8'd1;
    ifc.din = mem_rd(ifc.addr);
    @(negedge sys_clock);
  endtask

  task automatic applyStimulus(input logic irq, input logic brk, input logic nmi);
    ifc.sp_in    = 8'hFD;
    ifc.nmi_pend = nmi;
    ifc.int_req  = irq;
    ifc.brk_go   = brk;
    ifc.op_fetch = 1'b1;
    step();
    ifc.int_req  = 1'b0;
    ifc.brk_go   = 1'b0;
    ifc.op_fetch = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    clk_ph1      = 1'b1;
    ifc.int_req  = 1'b0;
    ifc.nmi_pend = 1'b0;
    ifc.brk_go   = 1'b0;
    ifc.op_fetch = 1'b0;
    ifc.pc_in    = 16'h1234;
    ifc.p_in     = 8'h00;
    ifc.sp_in    = 8'hFD;
    ifc.din      = 8'h00;
    @(negedge sys_clock);
    @(negedge sys_clock);

    checkOutput("rst_busy", {15'd0, ifc.busy}, 16'd1);
    checkOutput("rst_rw", {15'd0, ifc.rw}, 16'd1);
    checkOutput("rst_addr", ifc.addr, 16'h1234);
    checkOutput("rst_strobes", {11'd0, ifc.sp_dec, ifc.set_i, ifc.pc_load, ifc.int_clr, ifc.nmi_clr}, 16'd0);

    // Reset sequence: pushes turn into reads, vector from FFFC/FFFD.
    rst = 1'b1;
    step();
    checkOutput("rs_t2_addr", ifc.addr, 16'h01FD);
    checkOutput("rs_t2_rw", {15'd0, ifc.rw}, 16'd1);
    checkOutput("rs_t2_spdec", {15'd0, ifc.sp_dec}, 16'd1);
    step();
    checkOutput("rs_t3_rw", {15'd0, ifc.rw}, 16'd1);
    step();
    checkOutput("rs_t4_addr", ifc.addr, 16'h01FB);
    checkOutput("rs_t4_rw", {15'd0, ifc.rw}, 16'd1);
    step();
    checkOutput("rs_t5_addr", ifc.addr, 16'hFFFC);
    checkOutput("rs_t5_seti", {15'd0, ifc.set_i}, 16'd1);
    step();
    checkOutput("rs_t6_addr", ifc.addr, 16'hFFFD);
    checkOutput("rs_t6_pcload", {15'd0, ifc.pc_load}, 16'd1);
    checkOutput("rs_t6_pcvec", ifc.pc_vec, 16'h8000);
    step();
    checkOutput("rs_idle_busy", {15'd0, ifc.busy}, 16'd0);
    checkOutput("rs_idle_pcload", {15'd0, ifc.pc_load}, 16'd0);
    checkOutput("rs_idle_pcvec", ifc.pc_vec, 16'h8000);

    // Idle: op_fetch alone does not start a sequence.
    ifc.op_fetch = 1'b1;
    step();
    ifc.op_fetch = 1'b0;
    checkOutput("idle_opfetch_only", {15'd0, ifc.busy}, 16'd0);

    // IRQ entry.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("irq_t1_busy", {15'd0, ifc.busy}, 16'd1);
    checkOutput("irq_t1_addr", ifc.addr, 16'h1234);
    checkOutput("irq_t1_rw", {15'd0, ifc.rw}, 16'd1);
    step();
    checkOutput("irq_t2_addr", ifc.addr, 16'h01FD);
    checkOutput("irq_t2_dout", {8'd0, ifc.dout}, 16'h0012);
    checkOutput("irq_t2_rw", {15'd0, ifc.rw}, 16'd0);
    step();
    checkOutput("irq_t3_addr", ifc.addr, 16'h01FC);
    checkOutput("irq_t3_dout", {8'd0, ifc.dout}, 16'h0034);
    step();
    checkOutput("irq_t4_addr", ifc.addr, 16'h01FB);
    checkOutput("irq_t4_dout", {8'd0, ifc.dout}, 16'h0020);
    checkOutput("irq_t4_rw", {15'd0, ifc.rw}, 16'd0);
    step();
    checkOutput("irq_t5_addr", ifc.addr, 16'hFFFE);
    checkOutput("irq_t5_rw", {15'd0, ifc.rw}, 16'd1);
    step();
    checkOutput("irq_t6_addr", ifc.addr, 16'hFFFF);
    checkOutput("irq_t6_clr", {14'd0, ifc.int_clr, ifc.nmi_clr}, 16'b10);
    checkOutput("irq_t6_pcvec", ifc.pc_vec, 16'hA000);
    step();
    checkOutput("irq_idle", {14'd0, ifc.busy, ifc.int_clr}, 16'd0);

    // BRK entry, with a Phi1 gap in T2 and an int_req that must be ignored while busy.
    applyStimulus(1'b0, 1'b1, 1'b0);
    step();
    clk_ph1 = 1'b0;
    step();
    clk_ph1 = 1'b1;
    checkOutput("brk_ph1_hold_addr", ifc.addr, 16'h01FD);
    checkOutput("brk_ph1_hold_dout", {8'd0, ifc.dout}, 16'h0012);
    ifc.int_req  = 1'b1;
    ifc.op_fetch = 1'b1;
    step();
    ifc.int_req  = 1'b0;
    ifc.op_fetch = 1'b0;
    checkOutput("brk_t3_addr", ifc.addr, 16'h01FC);
    step();
    checkOutput("brk_t4_dout", {8'd0, ifc.dout}, 16'h0030);
    checkOutput("brk_t4_seti", {15'd0, ifc.set_i}, 16'd0);
    step();
    checkOutput("brk_t5_addr", ifc.addr, 16'hFFFE);
    checkOutput("brk_t5_seti", {15'd0, ifc.set_i}, 16'd1);
    step();
    checkOutput("brk_t6_seti", {15'd0, ifc.set_i}, 16'd0);
    checkOutput("brk_t6_pcload", {15'd0, ifc.pc_load}, 16'd1);
    step();
    checkOutput("brk_idle", {15'd0, ifc.busy}, 16'd0);

    // NMI pending at entry.
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    step();
    step();
    step();
    checkOutput("nmi_t5_addr", ifc.addr, 16'hFFFA);
    checkOutput("nmi_t5_clr", {14'd0, ifc.int_clr, ifc.nmi_clr}, 16'b00);
    step();
    checkOutput("nmi_t6_addr", ifc.addr, 16'hFFFB);
    checkOutput("nmi_t6_clr", {14'd0, ifc.int_clr, ifc.nmi_clr}, 16'b11);
    checkOutput("nmi_t6_pcvec", ifc.pc_vec, 16'h9000);
    step();
    checkOutput("nmi_idle_clr", {14'd0, ifc.int_clr, ifc.nmi_clr}, 16'b00);
    ifc.nmi_pend = 1'b0;

    // IRQ entry with NMI rising at T3.
    applyStimulus(1'b1, 1'b0, 1'b0);
    step();
    step();
    ifc.nmi_pend = 1'b1;
    step();
    checkOutput("hij_t4_dout", {8'd0, ifc.dout}, 16'h0020);
    step();
`ifdef NMI_HIJACK_EN
    checkOutput("hij_t5_addr", ifc.addr, 16'hFFFA);
`else
    checkOutput("hij_t5_addr", ifc.addr, 16'hFFFE);
`endif
    step();
`ifdef NMI_HIJACK_EN
    checkOutput("hij_t6_nmiclr", {15'd0, ifc.nmi_clr}, 16'd1);
`else
    checkOutput("hij_t6_nmiclr", {15'd0, ifc.nmi_clr}, 16'd0);
`endif
    step();
    ifc.nmi_pend = 1'b0;

    // IRQ entry with NMI rising at T5: vector unaffected.
    applyStimulus(1'b1, 1'b0, 1'b0);
    step();
    step();
    step();
    step();
    ifc.nmi_pend = 1'b1;
    step();
    checkOutput("late_nmi_t6_addr", ifc.addr, 16'hFFFF);
    checkOutput("late_nmi_t6_nmiclr", {15'd0, ifc.nmi_clr}, 16'd0);
    step();
    ifc.nmi_pend = 1'b0;

    // Abort in T3: reset takes over at once, then a full reset sequence follows.
    applyStimulus(1'b1, 1'b0, 1'b0);
    step();
    step();
    checkOutput("abort_t3_rw", {15'd0, ifc.rw}, 16'd0);
    rst = 1'b0;
    #1;
    checkOutput("abort_busy", {15'd0, ifc.busy}, 16'd1);
    checkOutput("abort_rw", {15'd0, ifc.rw}, 16'd1);
    checkOutput("abort_addr", ifc.addr, 16'h1234);
    checkOutput("abort_spdec", {15'd0, ifc.sp_dec}, 16'd0);
    @(negedge sys_clock);
    ifc.sp_in = 8'hFD;
    rst = 1'b1;
    step();
    checkOutput("abort_rs_t2_rw", {15'd0, ifc.rw}, 16'd1);
    step();
    step();
    step();
    checkOutput("abort_rs_t5_addr", ifc.addr, 16'hFFFC);
    step();
    checkOutput("abort_rs_t6_pcvec", ifc.pc_vec, 16'h8000);
    checkOutput("abort_rs_t6_pcload", {15'd0, ifc.pc_load}, 16'd1);
    step();
    checkOutput("abort_rs_idle", {15'd0, ifc.busy}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
